// File: rtl/inv_key_scheduler.sv
// inv_key_scheduler: iterative AES-256 inverse key expansion.
// Loads {rk13,rk14} and walks the key expansion backwards one round key per
// cycle. It streams rk14 down to rk0 over a valid/ready interface.
// Optional feature macro: INV_KEY_SCHED_CIPHER_KEY_EN. When it is defined,
// the module adds o_cipher_key = {rk0,rk1}, which is captured on the rk0
// handshake.
//
// Handshake: a key transfers on any rising edge where o_valid=1 and i_ready=1.
// While o_valid=1 and i_ready=0, o_round_key and o_round_idx hold stable.
// i_ready is ignored while o_valid=0. i_start is only honoured in IDLE.
module inv_key_scheduler #(
  parameter int NB_BYTE       = 8,
  parameter int N_BYTES_STATE = 16,
  parameter int N_BYTES_KEY   = 32,
  parameter int N_ROUNDS      = 14
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [255:0] i_key,
  input  logic         i_start,
  input  logic         i_ready,
  output logic [127:0] o_round_key,
  output logic [3:0]   o_round_idx,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done
`ifdef INV_KEY_SCHED_CIPHER_KEY_EN
  ,
  output logic [255:0] o_cipher_key
`endif
);

  // Only the AES-256 geometry with 8-bit bytes is implemented.
  localparam bit BAD_CONF = (NB_BYTE != 8) || (N_BYTES_STATE != 16) ||
                            (N_BYTES_KEY != 32) || (N_ROUNDS != 14);
  if (BAD_CONF) begin : g_bad_conf
    $error("inv_key_scheduler: only NB_BYTE=8, N_BYTES_KEY=32, N_ROUNDS=14 supported");
  end

  localparam logic [3:0] LAST_IDX = 4'd14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         state_q, state_d;
  logic [255:0]   win_q, win_d;     // w[b..b+7], w[b] in the MSBs
  logic [3:0]     idx_q, idx_d;
  logic           done_q, done_d;

  logic [31:0]    win_w [8];
  logic [31:0]    t_in, t_sub_in, t_out;
  logic [3:0]     idx_m1;
  logic [7:0]     rcon;
  logic [127:0]   prev_words;       // w[b-4..b-1], w[b-4] in the MSBs

  // Split the window into words and derive the four preceding words.
  // At index r the window base is b=4r, so rot+rcon applies when r is odd.
  always_comb begin
    for (int i = 0; i < 8; i++) win_w[i] = win_q[255 - 32*i -: 32];
    idx_m1     = idx_q - 4'd1;
    rcon       = 8'h01 << idx_m1[3:1];
    t_in       = win_w[3];
    t_sub_in   = idx_q[0] ? {t_in[23:0], t_in[31:24]} : t_in;
    t_out      = sub_word(t_sub_in) ^ (idx_q[0] ? {rcon, 24'h0} : 32'h0);
    prev_words = {win_w[4] ^ t_out, win_w[5] ^ win_w[4],
                  win_w[6] ^ win_w[5], win_w[7] ^ win_w[6]};
  end

  // Next-state logic: load on start, step backwards on each handshake.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          win_d   = i_key;
          idx_d   = LAST_IDX;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = idx_m1;           // rk13 is already in the window
          end else if (idx_q != 4'd0) begin
            win_d = {prev_words, win_q[255:128]};
            idx_d = idx_m1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, window, index and done registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign o_valid     = (state_q == S_RUN);
  assign o_busy      = (state_q == S_RUN);
  assign o_done      = done_q;
  assign o_round_idx = idx_q;
  // rk14 is the upper-indexed half of the initial window; every later key is
  // the lower-indexed half.
  assign o_round_key = (idx_q == LAST_IDX) ? win_q[127:0] : win_q[255:128];

`ifdef INV_KEY_SCHED_CIPHER_KEY_EN
  logic [255:0] cipher_q;
  logic         last_hs;

  assign last_hs = (state_q == S_RUN) && i_ready && (idx_q == 4'd0);

  // At index 0 the window is exactly {rk0,rk1}. Capture it on the last handshake.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cipher_q <= '0;
    else if (last_hs) cipher_q <= win_q;
  end

  assign o_cipher_key = cipher_q;
`endif

endmodule

// File: tb/tb_inv_key_scheduler.sv
// tb_inv_key_scheduler: scoreboard bench for inv_key_scheduler.
// Expected keys come from a forward AES-256 expansion model. That model
// builds its S-box arithmetically from GF(2^8). Hand constants from FIPS-197
// override the model for the first test.
module tb_inv_key_scheduler;

  logic         i_clock;
  logic         i_reset;
  logic [255:0] i_key;
  logic         i_start;
  logic         i_ready;
  logic [127:0] o_round_key;
  logic [3:0]   o_round_idx;
  logic         o_valid;
  logic         o_busy;
  logic         o_done;
`ifdef INV_KEY_SCHED_CIPHER_KEY_EN
  logic [255:0] o_cipher_key;
`endif

  inv_key_scheduler dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_key       (i_key),
    .i_start     (i_start),
    .i_ready     (i_ready),
    .o_round_key (o_round_key),
    .o_round_idx (o_round_idx),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
`ifdef INV_KEY_SCHED_CIPHER_KEY_EN
    ,
    .o_cipher_key(o_cipher_key)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [131:0] exp_q[$];      // {idx, round key}
  logic [255:0] ck_q[$];       // expected cipher key per sequence

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [31:0]  w_m [60];
  logic [127:0] rk_m [15];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      if (x != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gf_mul(inv, x);
      end
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  // Forward AES-256 expansion; fills rk_m[0..14].
  task automatic expand(input logic [255:0] key);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w_m[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w_m[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = rc << 1;
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w_m[i] = w_m[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++)
      rk_m[r] = {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endtask

  // ---------------- ready driver ----------------
  int         ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1
  logic [3:0] ready_pat  = 4'b1001;

  initial begin
    int cyc;
    cyc = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge i_clock);
      #1;
      if (ready_mode == 1) begin
        i_ready = ready_pat[cyc % 4];
        cyc++;
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the DUT able to accept a start.
  task automatic start_seq(input logic [255:0] cipher_key);
    for (int r = 14; r >= 0; r--) exp_q.push_back({4'(r), rk_m[r]});
    ck_q.push_back(cipher_key);
    i_key   = {rk_m[13], rk_m[14]};
    i_start = 1'b1;
    @(posedge i_clock);
    #1;
    i_start = 1'b0;
    i_key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    check("first_valid_latency", {o_valid, o_round_idx}, {1'b1, 4'd14});
  endtask

  // Returns at posedge+1 of the o_done cycle.
  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge i_clock);
      #1;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         done_exp, hold_v;
    logic [131:0] held, got, exp;
    done_exp = 1'b0;
    hold_v   = 1'b0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        done_exp = 1'b0;
        hold_v   = 1'b0;
      end else begin
        if (done_exp || o_done) check("done_pulse", o_done, done_exp);
`ifdef INV_KEY_SCHED_CIPHER_KEY_EN
        if (done_exp && ck_q.size() > 0) check("cipher_key", o_cipher_key, ck_q.pop_front());
`else
        if (done_exp && ck_q.size() > 0) void'(ck_q.pop_front());
`endif
        done_exp = 1'b0;
        got = {o_round_idx, o_round_key};
        if (hold_v) check("stall_hold", got, held);
        hold_v = 1'b0;
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_key: got %h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            check("round_key", got, exp);
            if (exp[131:128] == 4'd0) done_exp = 1'b1;
          end
        end else if (o_valid) begin
          held   = got;
          hold_v = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] k;
    logic         seen;
    build_sbox();
    i_reset = 1'b1;
    i_start = 1'b0;
    i_key   = '0;
    #3;
    check("reset_outputs", {o_valid, o_busy, o_done, o_round_idx, o_round_key}, '0);
`ifdef INV_KEY_SCHED_CIPHER_KEY_EN
    check("reset_cipher_key", o_cipher_key, '0);
`endif
    @(posedge i_clock);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;

    // Test 1: known key, always ready, hand constants for rk14/rk2/rk1/rk0.
    expand(KEY1);
    rk_m[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    rk_m[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    rk_m[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    rk_m[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    start_seq(KEY1);
    wait_done();
    @(posedge i_clock);
    #1;
    check("idle_after_done", {o_valid, o_busy}, 2'b00);

    // Test 2: same key with ready toggling 1,0,0,1.
    ready_mode = 1;
    expand(KEY1);
    start_seq(KEY1);
    wait_done();
    ready_mode = 0;
    @(posedge i_clock);
    #1;

    // Test 3: start pulses while busy, including the final handshake cycle.
    expand(KEY1);
    start_seq(KEY1);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge i_clock);
      #1;
      i_start = 1'b0;
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_valid && (o_round_idx == 4'd10 || o_round_idx == 4'd0)) begin
        i_key   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        i_start = 1'b1;
      end
    end
    check("busy_start_done_seen", seen, 1'b1);
    check("no_restart_on_final", {o_valid, o_busy}, 2'b00);
    @(posedge i_clock);
    #1;
    check("still_idle", {o_valid, o_busy}, 2'b00);

    // Test 4: asynchronous reset at idx 7, then a clean run.
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand(k);
    start_seq(k);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_round_idx == 4'd7) begin
        seen = 1'b1;
        break;
      end
      @(posedge i_clock);
      #1;
    end
    check("reached_idx7", seen, 1'b1);
    #3;
    i_reset = 1'b1;
    #1;
    check("async_reset_outputs", {o_valid, o_busy, o_done, o_round_idx, o_round_key}, '0);
    exp_q.delete();
    ck_q.delete();
    @(posedge i_clock);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    check("no_done_after_abort", o_done, 1'b0);
    expand(KEY1);
    start_seq(KEY1);
    wait_done();
    @(posedge i_clock);
    #1;

    // Test 5: random keys, one of them with a stalling sink.
    for (int n = 0; n < 3; n++) begin
      ready_mode = (n == 1) ? 1 : 0;
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(k);
      start_seq(k);
      wait_done();
      ready_mode = 0;
      @(posedge i_clock);
      #1;
    end

    // Test 6: start accepted on the o_done cycle.
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand(k);
    start_seq(k);
    wait_done();
    k = {$urandom_range(255, 0), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expand(k);
    start_seq(k);
    wait_done();

    repeat (3) @(posedge i_clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
